// File: rtl/uart_serial.sv
// rtl/uart_serial.sv - full-duplex 8N1 serial transceiver with a fixed clock divisor
// TX and RX are independent engines that share only clk and reset.

module uart_serial #(
   parameter int CLK_HZ  = 50000000,
   parameter int SCLK_HZ = 115200,
   parameter int WIDTH   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxd,
   input  logic             start,
   input  logic [WIDTH-1:0] data_tx,
   output logic             txd,
   output logic             busy,
   output logic             re,
   output logic [WIDTH-1:0] data_rx
);

   localparam int DIV = CLK_HZ / SCLK_HZ;
   localparam int CW  = $clog2(DIV);
   localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   tx_state_e        tx_state_q, tx_state_d;
   logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]    tx_bit_q, tx_bit_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic             txd_q, txd_d;

   rx_state_e        rx_state_q, rx_state_d;
   logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]    rx_bit_q, rx_bit_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic             rx_armed_q, rx_armed_d;
   logic             rxd_meta_q, rxd_meta_d;
   logic             rxd_sync_q, rxd_sync_d;
   logic             re_q, re_d;
   logic [WIDTH-1:0] data_rx_q, data_rx_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_armed_q <= 1'b1;
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         re_q       <= 1'b0;
         data_rx_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_armed_q <= rx_armed_d;
         rxd_meta_q <= rxd_meta_d;
         rxd_sync_q <= rxd_sync_d;
         re_q       <= re_d;
         data_rx_q  <= data_rx_d;
      end
   end

   // txd is registered and updated on the same edge as the state, so each bit
   // occupies exactly DIV cycles starting one cycle after start is taken.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (start) begin
               tx_shift_d = data_tx;
               tx_cnt_d   = CNT_FULL;
               txd_d      = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d   = CNT_FULL;
               tx_bit_d   = '0;
               txd_d      = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = CNT_FULL;
               if (tx_bit_q == BIT_LAST) begin
                  txd_d      = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + BIT_ONE;
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_STOP: begin
            txd_d = 1'b1;
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            txd_d      = 1'b1;
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   // After a framing error the receiver disarms until it sees the line high,
   // so a stuck-low stop bit is not mistaken for the next start bit.
   always_comb begin
      rxd_meta_d = rxd;
      rxd_sync_d = rxd_meta_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_armed_d = rx_armed_q;
      re_d       = 1'b0;
      data_rx_d  = data_rx_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_armed_q) begin
               rx_armed_d = rxd_sync_q;
            end else if (!rxd_sync_q) begin
               rx_cnt_d   = CNT_HALF;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rxd_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_cnt_d   = CNT_FULL;
                  rx_bit_d   = '0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rxd_sync_q, rx_shift_q[WIDTH-1:1]};
               rx_cnt_d   = CNT_FULL;
               if (rx_bit_q == BIT_LAST) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + BIT_ONE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = RX_IDLE;
               if (rxd_sync_q) begin
                  data_rx_d = rx_shift_q;
                  re_d      = 1'b1;
               end else begin
                  rx_armed_d = 1'b0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   assign txd     = txd_q;
   assign busy    = (tx_state_q != TX_IDLE);
   assign re      = re_q;
   assign data_rx = data_rx_q;

endmodule

// File: tb/tb_uart_serial.sv
// tb/tb_uart_serial.sv - scoreboard bench for uart_serial in txd->rxd loopback
// Expected frames are queued at stimulus time; negedge monitors pop and compare.

module tb_uart_serial;

   localparam int DIV    = 10;
   localparam int WIDTH  = 8;
   localparam int FRAME  = (WIDTH + 2) * DIV;
   localparam int RX_LAT = 2 + DIV / 2 + (WIDTH + 1) * DIV + 1;

   typedef struct {
      logic [7:0] data;
      int         due;
   } rx_exp_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] data_tx;
   logic       txd;
   logic       busy;
   logic       re;
   logic [7:0] data_rx;
   logic       rxd_drv;

   int         n_vec;
   int         n_err;
   int         cyc;
   logic [7:0] exp_hold;
   logic [7:0] tx_q[$];
   rx_exp_t    rx_q[$];

   uart_serial #(
      .CLK_HZ (50000000),
      .SCLK_HZ(5000000),
      .WIDTH  (WIDTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .rxd    (txd & rxd_drv),
      .start  (start),
      .data_tx(data_tx),
      .txd    (txd),
      .busy   (busy),
      .re     (re),
      .data_rx(data_rx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmit-side monitor: each busy frame must match start/data LSB-first/stop.
   initial begin
      logic [9:0] frame;
      int         t;
      bit         in_frame;
      bit         skip;
      in_frame = 0;
      skip     = 0;
      t        = 0;
      frame    = '1;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            in_frame = 0;
         end else begin
            if (!in_frame && busy === 1'b1) begin
               in_frame = 1;
               t        = 0;
               if (tx_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  skip = 1;
                  $display("FAIL tx_unexpected: got busy=1 required busy=0 (cycle %0d)", cyc);
               end else begin
                  skip  = 0;
                  frame = {1'b1, tx_q.pop_front(), 1'b0};
               end
            end
            if (in_frame) begin
               if (!skip) begin
                  chk("txd_bit", txd, frame[t / DIV]);
                  chk("busy_in_frame", busy, 1);
               end
               t++;
               if (t == FRAME) in_frame = 0;
            end
         end
      end
   end

   // Receive-side monitor: every re must match the oldest pending frame and its due cycle.
   initial begin
      rx_exp_t e;
      logic    re_prev;
      re_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            re_prev = 1'b0;
         end else begin
            if (re === 1'b1) begin
               chk("re_single_cycle", re_prev, 0);
               if (rx_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL rx_unexpected: got re=1 data_rx=%0h required re=0 (cycle %0d)", data_rx, cyc);
               end else begin
                  e = rx_q.pop_front();
                  chk("rx_data", data_rx, e.data);
                  chk("re_cycle", cyc, e.due);
                  exp_hold = e.data;
               end
            end
            re_prev = re;
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 300 && rx_q.size() != 0; i++) @(negedge clk);
      chk("rx_pending", rx_q.size(), 0);
   endtask

   task automatic wait_busy_low(input string name, output int n);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic send_tx(input logic [7:0] b);
      rx_exp_t e;
      int      n;
      @(posedge clk); #1;
      data_tx = b;
      start   = 1'b1;
      tx_q.push_back(b);
      e.data = b;
      e.due  = cyc + 1 + RX_LAT;
      rx_q.push_back(e);
      @(posedge clk); #1;
      start   = 1'b0;
      data_tx = 8'($urandom);
      @(negedge clk);
      chk("tx_latency_txd", txd, 0);
      wait_busy_low("busy_len", n);
      chk("busy_len", n, FRAME);
      drain();
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
      rx_exp_t    e;
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      @(posedge clk); #1;
      if (stop_bit) begin
         e.data = b;
         e.due  = cyc + RX_LAT;
         rx_q.push_back(e);
      end
      for (int k = 0; k < 10; k++) begin
         rxd_drv = fr[k];
         repeat (DIV) @(posedge clk);
         #1;
      end
      rxd_drv = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rx_exp_t e;
      int      n;
      int      p0;
      n_vec    = 0;
      n_err    = 0;
      exp_hold = 8'h00;
      reset    = 1'b0;
      start    = 1'b0;
      data_tx  = 8'h00;
      rxd_drv  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_re", re, 0);
      chk("rst_data_rx", data_rx, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);

      send_tx(8'h41);
      send_tx(8'h01);

      // start held through a frame: exactly one frame, then a restart one cycle after busy falls
      @(posedge clk); #1;
      data_tx = 8'h55;
      start   = 1'b1;
      p0      = cyc + 1;
      tx_q.push_back(8'h55);
      tx_q.push_back(8'hC3);
      e.data = 8'h55;  e.due = p0 + RX_LAT;             rx_q.push_back(e);
      e.data = 8'hC3;  e.due = p0 + FRAME + 1 + RX_LAT; rx_q.push_back(e);
      @(posedge clk); #1;
      data_tx = 8'hC3;
      @(negedge clk);
      wait_busy_low("held_busy_len", n);
      chk("held_busy_len", n, FRAME);
      chk("held_fall_cycle", cyc, p0 + FRAME);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("held_restart", busy, 1);
      wait_busy_low("held_busy_len2", n);
      chk("held_busy_len2", n, FRAME);
      drain();

      // glitch shorter than half a bit must be ignored
      @(posedge clk); #1;
      rxd_drv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rxd_drv = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("glitch_hold", data_rx, exp_hold);
      drive_rx(8'h5A, 1'b1);
      drain();

      // framing error: byte discarded, data_rx unchanged, next frame still decoded
      drive_rx(8'hA5, 1'b0);
      repeat (2 * DIV) @(posedge clk);
      @(negedge clk);
      chk("framing_hold", data_rx, exp_hold);
      drive_rx(8'h33, 1'b1);
      drain();

      for (int i = 0; i < 4; i++) send_tx(8'($urandom));
      for (int i = 0; i < 4; i++) begin
         drive_rx(8'($urandom), 1'b1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();

      // reset 40 cycles into a transmit frame
      @(posedge clk); #1;
      data_tx = 8'h96;
      start   = 1'b1;
      tx_q.push_back(8'h96);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      reset = 1'b0;
      rx_q.delete();
      @(posedge clk); #1;
      reset    = 1'b1;
      exp_hold = 8'h00;
      tx_q.delete();
      @(negedge clk);
      chk("midrst_txd", txd, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_re", re, 0);
      chk("midrst_data_rx", data_rx, 0);
      send_tx(8'($urandom));

      repeat (5) @(posedge clk);
      chk("tx_q_empty", tx_q.size(), 0);
      chk("rx_q_empty", rx_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
